// File: rtl/sprite_blitter_pkg.sv
// Shared types and default dimensions for the sprite blitter.
package blit_pkg;

   typedef enum logic [1:0] {
      CMD_CLEAR  = 2'd0,
      CMD_RECT   = 2'd1,
      CMD_SPRITE = 2'd2,
      CMD_RSVD   = 2'd3
   } cmd_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int DEF_SCR_W     = 160;
   localparam int DEF_SCR_H     = 120;
   localparam int DEF_SPR_W     = 11;
   localparam int DEF_SPR_H     = 16;
   localparam int DEF_N_SPR     = 53;
   localparam int DEF_CW        = 3;
   localparam int CARD_BACK_IDX = 52;

endpackage

// File: rtl/sprite_blitter_if.sv
// Command port from the game FSM plus the pixel stream towards the VGA adapter.
interface sprite_blitter_if #(
   parameter int XW = 8,
   parameter int YW = 7,
   parameter int IW = 6,
   parameter int CW = 3
);
   logic          write;
   logic [1:0]    cmd;
   logic [IW-1:0] index;
   logic [XW-1:0] orig_x;
   logic [YW-1:0] orig_y;
   logic [CW-1:0] colour;
   logic          waitrequest;
   logic [XW-1:0] vga_x;
   logic [YW-1:0] vga_y;
   logic [CW-1:0] vga_colour;
   logic          vga_plot;

   modport master (
      output write, cmd, index, orig_x, orig_y, colour,
      input  waitrequest, vga_x, vga_y, vga_colour, vga_plot
   );

   modport slave (
      input  write, cmd, index, orig_x, orig_y, colour,
      output waitrequest, vga_x, vga_y, vga_colour, vga_plot
   );
endinterface

// File: rtl/sprite_blitter_rom.sv
// Sprite image ROM with one cycle of read latency. The image is supplied as a
// packed parameter (entry i occupies bits [i*CW +: CW]), built from the hex image.
module sprite_rom #(
   parameter int AW    = 14,
   parameter int CW    = 3,
   parameter int DEPTH = 9328,
   parameter logic [DEPTH*CW-1:0] INIT = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] addr,
   output logic [CW-1:0] data
);
   logic [CW-1:0] mem_s [0:DEPTH-1];

   for (genvar i = 0; i < DEPTH; i++) begin : g_img
      assign mem_s[i] = INIT[i*CW +: CW];
   end

   // registered read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
      end else begin
         data <= mem_s[addr];
      end
   end
endmodule

// File: rtl/sprite_blitter.sv
// Draw-command engine: clear, solid rectangle and clipped, keyed ROM sprites,
// streamed in raster order with a fixed three-cycle pixel latency.
module sprite_blitter
   import blit_pkg::*;
#(
   parameter int SCR_W      = DEF_SCR_W,
   parameter int SCR_H      = DEF_SCR_H,
   parameter int SPR_W      = DEF_SPR_W,
   parameter int SPR_H      = DEF_SPR_H,
   parameter int N_SPR      = DEF_N_SPR,
   parameter int CW         = DEF_CW,
   parameter int TRANSP_EN  = 1,
   parameter int TRANSP_COL = 7,
   parameter logic [N_SPR*SPR_W*SPR_H*CW-1:0] ROM_INIT = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   sprite_blitter_if.slave bus
);
   localparam int XW    = $clog2(SCR_W);
   localparam int YW    = $clog2(SCR_H);
   localparam int IW    = $clog2(N_SPR);
   localparam int DEPTH = N_SPR * SPR_W * SPR_H;
   localparam int AW    = $clog2(DEPTH);
   localparam int XW1   = XW + 1;
   localparam int YW1   = YW + 1;
   localparam int IW1   = IW + 1;

   localparam logic [XW1-1:0] SCR_W_V   = XW1'(SCR_W);
   localparam logic [YW1-1:0] SCR_H_V   = YW1'(SCR_H);
   localparam logic [IW1-1:0] N_SPR_V   = IW1'(N_SPR);
   localparam logic [AW-1:0]  SPR_PIX_V = AW'(SPR_W * SPR_H);
   localparam logic [CW-1:0]  KEY_V     = CW'(TRANSP_COL);

   // stage 1: sequencer and scan counters
   state_e        state_r;
   logic          wait_r, drain_r, spr_r;
   logic [XW-1:0] ox_r, col_r, lim_c_r;
   logic [YW-1:0] oy_r, row_r, lim_r_r;
   logic [CW-1:0] fill_r;
   logic [AW-1:0] addr_r;
   // stage 2: delayed coordinates next to ROM data
   logic           s2_vld_r, s2_spr_r;
   logic [XW1-1:0] s2_x_r;
   logic [YW1-1:0] s2_y_r;
   logic [CW-1:0]  s2_fill_r;
   logic [CW-1:0]  rom_q_s;
   // output registers
   logic [XW-1:0] vga_x_r;
   logic [YW-1:0] vga_y_r;
   logic [CW-1:0] vga_colour_r;
   logic          vga_plot_r;

   logic           accept_s, plot_s;
   logic [AW-1:0]  base_s;
   logic [XW1-1:0] sx_s;
   logic [YW1-1:0] sy_s;

   sprite_rom #(.AW(AW), .CW(CW), .DEPTH(DEPTH), .INIT(ROM_INIT)) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr_r),
      .data  (rom_q_s)
   );

   // command acceptance: reserved opcodes and out-of-range sprites are dropped
   always_comb begin
      accept_s = 1'b0;
      base_s   = AW'(bus.index) * SPR_PIX_V;
      if (state_r == IDLE && bus.write) begin
         case (cmd_e'(bus.cmd))
            CMD_CLEAR:  accept_s = 1'b1;
            CMD_RECT:   accept_s = 1'b1;
            CMD_SPRITE: accept_s = ({1'b0, bus.index} < N_SPR_V);
            default:    accept_s = 1'b0;
         endcase
      end else begin
         accept_s = 1'b0;
      end
   end

   // screen coordinates of the pixel in stage 1, one spare bit for clipping
   always_comb begin
      sx_s = {1'b0, ox_r} + {1'b0, col_r};
      sy_s = {1'b0, oy_r} + {1'b0, row_r};
   end

   // sequencer FSM: latch command, raster scan, two-cycle drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         wait_r  <= 1'b0;
         drain_r <= 1'b0;
         spr_r   <= 1'b0;
         ox_r    <= '0;
         oy_r    <= '0;
         col_r   <= '0;
         row_r   <= '0;
         lim_c_r <= '0;
         lim_r_r <= '0;
         fill_r  <= '0;
         addr_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  state_r <= SCAN;
                  wait_r  <= 1'b1;
                  drain_r <= 1'b0;
                  col_r   <= '0;
                  row_r   <= '0;
                  fill_r  <= bus.colour;
                  if (cmd_e'(bus.cmd) == CMD_CLEAR) begin
                     spr_r   <= 1'b0;
                     ox_r    <= '0;
                     oy_r    <= '0;
                     lim_c_r <= XW'(SCR_W - 1);
                     lim_r_r <= YW'(SCR_H - 1);
                     addr_r  <= '0;
                  end else begin
                     spr_r   <= (cmd_e'(bus.cmd) == CMD_SPRITE);
                     ox_r    <= bus.orig_x;
                     oy_r    <= bus.orig_y;
                     lim_c_r <= XW'(SPR_W - 1);
                     lim_r_r <= YW'(SPR_H - 1);
                     addr_r  <= (cmd_e'(bus.cmd) == CMD_SPRITE) ? base_s : '0;
                  end
               end
            end
            SCAN: begin
               // the address counter only walks for sprites so it stays inside the ROM
               if (spr_r) begin
                  addr_r <= addr_r + AW'(1);
               end
               if (col_r == lim_c_r) begin
                  col_r <= '0;
                  if (row_r == lim_r_r) begin
                     state_r <= DRAIN;
                  end else begin
                     row_r <= row_r + YW'(1);
                  end
               end else begin
                  col_r <= col_r + XW'(1);
               end
            end
            DRAIN: begin
               if (drain_r) begin
                  state_r <= IDLE;
                  wait_r  <= 1'b0;
               end else begin
                  drain_r <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               wait_r  <= 1'b0;
            end
         endcase
      end
   end

   // stage 2: carry coordinates and fill alongside the ROM read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld_r  <= 1'b0;
         s2_spr_r  <= 1'b0;
         s2_x_r    <= '0;
         s2_y_r    <= '0;
         s2_fill_r <= '0;
      end else begin
         s2_vld_r  <= (state_r == SCAN);
         s2_spr_r  <= spr_r;
         s2_x_r    <= sx_s;
         s2_y_r    <= sy_s;
         s2_fill_r <= fill_r;
      end
   end

   // plot decision: valid, on screen, and not the sprite colour key
   always_comb begin
      plot_s = 1'b0;
      if (!s2_vld_r) begin
         plot_s = 1'b0;
      end else if (s2_x_r >= SCR_W_V || s2_y_r >= SCR_H_V) begin
         plot_s = 1'b0;
      end else if (s2_spr_r && TRANSP_EN != 0 && rom_q_s == KEY_V) begin
         plot_s = 1'b0;
      end else begin
         plot_s = 1'b1;
      end
   end

   // output registers towards the VGA adapter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_x_r      <= '0;
         vga_y_r      <= '0;
         vga_colour_r <= '0;
         vga_plot_r   <= 1'b0;
      end else begin
         vga_x_r      <= s2_x_r[XW-1:0];
         vga_y_r      <= s2_y_r[YW-1:0];
         vga_colour_r <= s2_spr_r ? rom_q_s : s2_fill_r;
         vga_plot_r   <= plot_s;
      end
   end

   assign bus.waitrequest = wait_r;
   assign bus.vga_x       = vga_x_r;
   assign bus.vga_y       = vga_y_r;
   assign bus.vga_colour  = vga_colour_r;
   assign bus.vga_plot    = vga_plot_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed and randomised commands
// compared cycle by cycle against a raster-order reference model.
module tb_sprite_blitter;
   import blit_pkg::*;

   localparam int SCR_W = 160;
   localparam int SCR_H = 120;
   localparam int SPR_W = 11;
   localparam int SPR_H = 16;
   localparam int N_SPR = 53;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   sprite_blitter_if #(.XW(8), .YW(7), .IW(6), .CW(3)) bus ();

   // ROM image: entry a holds a mod 8 (pattern 0..7 repeated 1166 times)
   sprite_blitter #(.ROM_INIT({1166{24'hFAC688}})) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // reference: pixel k of a command, straight from the drawing rules
   function automatic void ref_pix(input int c, input int idx, input int ox, input int oy,
                                   input int fill, input int k,
                                   output bit plot, output int x, output int y, output int col);
      int w;
      w = (c == 0) ? SCR_W : SPR_W;
      if (c == 0) begin
         ox = 0;
         oy = 0;
      end
      x   = ox + k % w;
      y   = oy + k / w;
      col = (c == 2) ? (idx * SPR_W * SPR_H + k) % 8 : fill;
      plot = (x < SCR_W) && (y < SCR_H) && !(c == 2 && col == 7);
   endfunction

   task automatic drive_idle();
      bus.write  = 1'b0;
      bus.cmd    = 2'd0;
      bus.index  = 6'd0;
      bus.orig_x = 8'd0;
      bus.orig_y = 7'd0;
      bus.colour = 3'd0;
   endtask

   // issue one command (called at a negedge with the blitter idle) and check
   // every cycle up to and including the first idle cycle; inj>0 fires a RECT
   // write during that busy cycle, which must be ignored
   task automatic run_cmd(input int c, input int idx, input int ox, input int oy,
                          input int fill, input int exp_plots, input int inj);
      int  n_pix, plots, x, y, col;
      bit  p;
      n_pix = (c == 0) ? SCR_W * SCR_H : SPR_W * SPR_H;
      plots = 0;
      bus.write  = 1'b1;
      bus.cmd    = 2'(c);
      bus.index  = 6'(idx);
      bus.orig_x = 8'(ox);
      bus.orig_y = 7'(oy);
      bus.colour = 3'(fill);
      @(posedge clk);
      for (int n = 1; n <= n_pix + 3; n++) begin
         @(negedge clk);
         if (n == inj) begin
            bus.write  = 1'b1;
            bus.cmd    = 2'd1;
            bus.orig_x = 8'd40;
            bus.orig_y = 7'd50;
            bus.colour = 3'd0;
         end else begin
            bus.write = 1'b0;
         end
         chk("busy", 32'(bus.waitrequest), 32'(n <= n_pix + 2));
         if (n >= 3 && n - 3 < n_pix) begin
            ref_pix(c, idx, ox, oy, fill, n - 3, p, x, y, col);
            chk("plot", 32'(bus.vga_plot), 32'(p));
            if (p) begin
               plots++;
               chk("x", 32'(bus.vga_x), 32'(x));
               chk("y", 32'(bus.vga_y), 32'(y));
               chk("colour", 32'(bus.vga_colour), 32'(col));
            end
         end else begin
            chk("idle_plot", 32'(bus.vga_plot), 32'd0);
         end
      end
      if (exp_plots >= 0) chk("plot_count", 32'(plots), 32'(exp_plots));
   endtask

   // a write that must be swallowed without starting anything
   task automatic noop_cmd(input int c, input int idx);
      bus.write = 1'b1;
      bus.cmd   = 2'(c);
      bus.index = 6'(idx);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         bus.write = 1'b0;
         chk("noop_busy", 32'(bus.waitrequest), 32'd0);
         chk("noop_plot", 32'(bus.vga_plot), 32'd0);
      end
   endtask

   initial begin
      int c, idx, ox, oy, fill;
      drive_idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.waitrequest), 32'd0);
      chk("rst_plot", 32'(bus.vga_plot), 32'd0);
      chk("rst_x", 32'(bus.vga_x), 32'd0);
      chk("rst_y", 32'(bus.vga_y), 32'd0);
      chk("rst_colour", 32'(bus.vga_colour), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // full clear, then a sprite issued in the clear's first idle cycle
      run_cmd(0, 0, 0, 0, 2, 19200, 0);
      run_cmd(2, 5, 20, 30, 0, 154, 0);
      // corner sprite: 5x10 on screen, 6 of those are colour key 7 -> 44
      run_cmd(2, 0, 155, 110, 0, 44, 0);
      // write during a busy clear is ignored, then the same RECT for real
      run_cmd(0, 0, 0, 0, 5, 19200, 100);
      run_cmd(1, 0, 40, 50, 0, 176, 0);
      // card back at the right screen edge
      run_cmd(2, CARD_BACK_IDX, 150, 0, 0, -1, 0);
      // completely off-screen rectangle
      run_cmd(1, 0, 200, 125, 6, 0, 0);

      noop_cmd(3, 0);
      noop_cmd(2, 60);
      noop_cmd(2, N_SPR);

      for (int i = 0; i < 8; i++) begin
         c    = int'($urandom_range(1, 2));
         idx  = int'($urandom_range(0, N_SPR - 1));
         ox   = int'($urandom_range(0, 255));
         oy   = int'($urandom_range(0, 127));
         fill = int'($urandom_range(0, 7));
         run_cmd(c, idx, ox, oy, fill, -1, 0);
      end

      // asynchronous reset in the middle of a sprite
      bus.write  = 1'b1;
      bus.cmd    = 2'd2;
      bus.index  = 6'd3;
      bus.orig_x = 8'd10;
      bus.orig_y = 7'd10;
      @(posedge clk);
      bus.write = 1'b0;
      repeat (40) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.waitrequest), 32'd0);
      chk("arst_plot", 32'(bus.vga_plot), 32'd0);
      chk("arst_x", 32'(bus.vga_x), 32'd0);
      chk("arst_y", 32'(bus.vga_y), 32'd0);
      chk("arst_colour", 32'(bus.vga_colour), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("abandon_busy", 32'(bus.waitrequest), 32'd0);
         chk("abandon_plot", 32'(bus.vga_plot), 32'd0);
      end
      run_cmd(0, 0, 0, 0, 3, 19200, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
